// File: rtl/btn_event_arbiter.sv
// Debounced button event classifier (PRESS/LONG/REPEAT/RELEASE) with a round-robin shared event channel.
// Define BTN_AUTOREPEAT_EN to enable REPEAT events while a button stays held after LONG.

module btn_evt_fsm #(
    parameter int LONG_TICKS   = 200,
    parameter int REPEAT_TICKS = 40,
    parameter int CNT_W        = 8
) (
    input  logic       clk_5ms,
    input  logic       rst,
    input  logic       deb,
    output logic       post,
    output logic [1:0] post_type
);
    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_LONG    = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    generate
        if ((2 ** CNT_W) <= LONG_TICKS || (2 ** CNT_W) <= REPEAT_TICKS) begin : g_bad_cnt_w
            $error("CNT_W too small for LONG_TICKS/REPEAT_TICKS");
        end
    endgenerate

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD, S_REPEAT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             btn_q;

    always_ff @(posedge clk_5ms or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            btn_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            btn_q <= deb;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        post      = 1'b0;
        post_type = EV_PRESS;
        case (state)
            S_IDLE: begin
                if (deb && !btn_q) begin
                    post    = 1'b1;
                    cnt_n   = '0;
                    state_n = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (!deb) begin
                    post      = 1'b1;
                    post_type = EV_RELEASE;
                    cnt_n     = '0;
                    state_n   = S_IDLE;
                end else if (cnt == CNT_W'(LONG_TICKS - 1)) begin
                    post      = 1'b1;
                    post_type = EV_LONG;
                    cnt_n     = '0;
                    state_n   = S_HELD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            S_HELD, S_REPEAT: begin
                if (!deb) begin
                    post      = 1'b1;
                    post_type = EV_RELEASE;
                    cnt_n     = '0;
                    state_n   = S_IDLE;
                end else if (cnt == CNT_W'(REPEAT_TICKS - 1)) begin
                    post      = 1'b1;
                    post_type = EV_REPEAT;
                    cnt_n     = '0;
                    state_n   = S_REPEAT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`else
            // Terminal until release; the counter stays at 0 from the LONG clear.
            S_HELD: begin
                if (!deb) begin
                    post      = 1'b1;
                    post_type = EV_RELEASE;
                    state_n   = S_IDLE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end
endmodule

module btn_event_arbiter #(
    parameter int NUM_BTN      = 4,
    parameter int ID_W         = 2,
    parameter int LONG_TICKS   = 200,
    parameter int REPEAT_TICKS = 40,
    parameter int CNT_W        = 8
) (
    input  logic               clk_5ms,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_deb,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    output logic [1:0]         evt_type,
    input  logic               evt_ack,
    output logic [NUM_BTN-1:0] pend,
    output logic               ovf
);
    generate
        if ((2 ** ID_W) < NUM_BTN) begin : g_bad_id_w
            $error("ID_W too small for NUM_BTN");
        end
    endgenerate

    logic [NUM_BTN-1:0]      post;
    logic [NUM_BTN-1:0][1:0] post_type;
    logic [NUM_BTN-1:0][1:0] slot;
    logic [ID_W-1:0]         ptr, sel, cand, ptr_n;
    logic                    hit, load, gnt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_evt_fsm #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk_5ms  (clk_5ms),
            .rst      (rst),
            .deb      (btn_deb[i]),
            .post     (post[i]),
            .post_type(post_type[i])
        );
    end

    // Search only the registered pend; same-edge posts wait one cycle.
    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        cand = '0;
        for (int o = 0; o < NUM_BTN; o++) begin
            cand = ID_W'((int'(ptr) + o) % NUM_BTN);
            if (!hit && pend[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        ptr_n = ID_W'((int'(sel) + 1) % NUM_BTN);
        load  = !evt_valid || evt_ack;
        gnt   = load && hit;
    end

    always_ff @(posedge clk_5ms or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            slot      <= '0;
            ovf       <= 1'b0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_type  <= 2'b00;
            ptr       <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                // A post wins over a same-edge grant; the grant already took the old slot.
                if (post[i]) begin
                    pend[i] <= 1'b1;
                    slot[i] <= post_type[i];
                    if (pend[i] && !(gnt && sel == ID_W'(i)))
                        ovf <= 1'b1;
                end else if (gnt && sel == ID_W'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
            if (load) begin
                if (hit) begin
                    evt_valid <= 1'b1;
                    evt_id    <= sel;
                    evt_type  <= slot[sel];
                    ptr       <= ptr_n;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed self-checking bench for btn_event_arbiter (default parameters).
module tb_btn_event_arbiter;
    logic       clk_5ms = 1'b0;
    logic       rst;
    logic [3:0] btn_deb;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [1:0] evt_type;
    logic       evt_ack;
    logic [3:0] pend;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int id;
        int typ;
        int cyc;
    } ev_t;
    ev_t evq[$];

    btn_event_arbiter dut (
        .clk_5ms  (clk_5ms),
        .rst      (rst),
        .btn_deb  (btn_deb),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_type (evt_type),
        .evt_ack  (evt_ack),
        .pend     (pend),
        .ovf      (ovf)
    );

    always #5 clk_5ms = ~clk_5ms;
    always @(posedge clk_5ms) cyc <= cyc + 1;

    // Inputs change only just after posedge, so negedge sees what the next edge will handshake.
    always @(negedge clk_5ms)
        if (!rst && evt_valid === 1'b1 && evt_ack === 1'b1)
            evq.push_back('{int'(evt_id), int'(evt_type), cyc});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_5ms);
        #1;
    endtask

    task automatic chk_ev(input string tag, input int idx, input int id, input int typ);
        chk({tag, "_id"}, evq[idx].id, id);
        chk({tag, "_type"}, evq[idx].typ, typ);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int ids[10];
        int typs[10];
        ids  = '{0, 2, 3, 0, 2, 3, 0, 3, 0, 3};
        typs = '{0, 0, 0, 3, 3, 3, 0, 0, 3, 3};

        rst = 1'b1; btn_deb = '0; evt_ack = 1'b0;
        #12;
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_pend", pend, 0);
        chk("rst_ovf", ovf, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Single press, short hold, release
        evt_ack = 1'b1;
        evq.delete();
        btn_deb[1] = 1'b1;
        tick(1);
        chk("p1_pend", pend, 4'b0010);
        chk("p1_valid0", evt_valid, 0);
        tick(1);
        chk("p1_valid", evt_valid, 1);
        chk("p1_id", evt_id, 1);
        chk("p1_type", evt_type, 0);
        tick(48);
        btn_deb[1] = 1'b0;
        tick(2);
        chk("r1_valid", evt_valid, 1);
        chk("r1_id", evt_id, 1);
        chk("r1_type", evt_type, 3);
        tick(2);
        chk("p1_count", evq.size(), 2);
        chk_ev("p1_ev0", 0, 1, 0);
        chk_ev("p1_ev1", 1, 1, 3);

        // Long hold on button 0
        evq.delete();
        btn_deb[0] = 1'b1;
        tick(300);
        btn_deb[0] = 1'b0;
        tick(5);
`ifdef BTN_AUTOREPEAT_EN
        chk("long_count", evq.size(), 5);
        chk_ev("long_ev0", 0, 0, 0);
        chk_ev("long_ev1", 1, 0, 1);
        chk("long_dt", evq[1].cyc - evq[0].cyc, 200);
        chk_ev("long_ev2", 2, 0, 2);
        chk("rep1_dt", evq[2].cyc - evq[0].cyc, 240);
        chk_ev("long_ev3", 3, 0, 2);
        chk("rep2_dt", evq[3].cyc - evq[0].cyc, 280);
        chk_ev("long_ev4", 4, 0, 3);
        chk("rel_dt", evq[4].cyc - evq[0].cyc, 300);
`else
        chk("long_count", evq.size(), 3);
        chk_ev("long_ev0", 0, 0, 0);
        chk_ev("long_ev1", 1, 0, 1);
        chk("long_dt", evq[1].cyc - evq[0].cyc, 200);
        chk_ev("long_ev2", 2, 0, 3);
        chk("rel_dt", evq[2].cyc - evq[0].cyc, 300);
`endif

        // Round-robin ordering from pointer 0
        rst_pulse();
        evq.delete();
        evt_ack = 1'b1;
        btn_deb = 4'b1101;
        tick(6);
        btn_deb = 4'b0000;
        tick(6);
        btn_deb = 4'b1001;
        tick(6);
        btn_deb = 4'b0000;
        tick(6);
        chk("rr_count", evq.size(), 10);
        for (int i = 0; i < 10; i++)
            chk_ev($sformatf("rr_ev%0d", i), i, ids[i], typs[i]);
        chk("rr_b2b1", evq[1].cyc - evq[0].cyc, 1);
        chk("rr_b2b2", evq[2].cyc - evq[1].cyc, 1);

        // Overwrite while channel is blocked
        rst_pulse();
        evt_ack = 1'b0;
        btn_deb[2] = 1'b1;
        tick(2);
        chk("ov_valid", evt_valid, 1);
        chk("ov_id", evt_id, 2);
        btn_deb[2] = 1'b0;
        tick(1);
        chk("ov_pend", pend, 4'b0100);
        chk("ov_ovf0", ovf, 0);
        btn_deb[2] = 1'b1;
        tick(1);
        btn_deb[2] = 1'b0;
        tick(1);
        chk("ov_ovf1", ovf, 1);
        chk("ov_hold_valid", evt_valid, 1);
        chk("ov_hold_id", evt_id, 2);
        chk("ov_hold_type", evt_type, 0);
        evt_ack = 1'b1;
        tick(1);
        chk("ov_next_valid", evt_valid, 1);
        chk("ov_next_type", evt_type, 3);
        tick(1);
        chk("ov_drain_valid", evt_valid, 0);
        chk("ov_drain_pend", pend, 0);
        chk("ov_sticky", ovf, 1);

        // Same-edge grant and new post on the same button
        rst_pulse();
        evt_ack = 1'b0;
        btn_deb[1] = 1'b1;
        tick(2);
        btn_deb[1] = 1'b0;
        tick(1);
        chk("se_pend", pend, 4'b0010);
        chk("se_type0", evt_type, 0);
        evt_ack = 1'b1;
        btn_deb[1] = 1'b1;
        tick(1);
        chk("se_valid1", evt_valid, 1);
        chk("se_type1", evt_type, 3);
        chk("se_pend1", pend, 4'b0010);
        chk("se_ovf1", ovf, 0);
        tick(1);
        chk("se_valid2", evt_valid, 1);
        chk("se_id2", evt_id, 1);
        chk("se_type2", evt_type, 0);
        chk("se_ovf2", ovf, 0);

        // Asynchronous reset with an event outstanding
        evt_ack = 1'b0;
        btn_deb = '0;
        tick(1);
        chk("ar_pre_valid", evt_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_valid", evt_valid, 0);
        chk("ar_id", evt_id, 0);
        chk("ar_type", evt_type, 0);
        chk("ar_pend", pend, 0);
        chk("ar_ovf", ovf, 0);
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("ar_post_valid", evt_valid, 0);
        chk("ar_post_pend", pend, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Sequences up to NUM_BTN debounced button lines, all clocked at the 5 ms debounce tick.
- Classifies each button's activity into PRESS / LONG / REPEAT / RELEASE events.
- A round-robin arbiter grants one shared valid/ack event channel to the consumer (menu/flash-test controller).
- Sits directly downstream of the per-button debounce stages.

Parameters:
NUM_BTN, 4, number of debounced button inputs (2..8)
ID_W, 2, width of evt_id; must satisfy 2**ID_W >= NUM_BTN
LONG_TICKS, 200, clk_5ms cycles held before LONG event (1 s)
REPEAT_TICKS, 40, clk_5ms cycles between REPEAT events after LONG (200 ms)
CNT_W, 8, hold-counter width; must hold max(LONG_TICKS, REPEAT_TICKS)

Ports:
clk_5ms  in  1  200 Hz debounce tick clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
btn_deb  in  NUM_BTN  debounced button levels, 1 = pressed
evt_valid  out  1  event available on evt_id/evt_type
evt_id  out  ID_W  index of the button that produced the event
evt_type  out  2  00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE
evt_ack  in  1  consumer accepts the event; handshake completes on an edge where evt_valid & evt_ack
pend  out  NUM_BTN  per-button pending-event flags
ovf  out  1  sticky: a pending event was overwritten before being granted

Behaviour:
- Reset (async): all per-button FSMs in IDLE, counters 0, btn_q 0, pend 0, evt_valid 0, evt_id 0, evt_type 00, ovf 0, round-robin pointer 0.
- Per button i, btn_q[i] registers btn_deb[i] (edge detect).
- FSM states: IDLE, PRESSED, HELD, REPEAT.
  - IDLE: on btn_deb=1 and btn_q=0, post PRESS, clear counter, go to PRESSED.
  - PRESSED: counter increments each cycle. When counter reaches LONG_TICKS-1, post LONG, clear counter, go to HELD.
  - HELD: counter increments. When counter reaches REPEAT_TICKS-1, post REPEAT, clear counter, go to REPEAT.
  - REPEAT: same REPEAT_TICKS period, one REPEAT event each period.
  - Any non-IDLE state: btn_deb=0 posts RELEASE and returns to IDLE. Release takes priority over a LONG/REPEAT due on the same cycle.
- Posting an event sets pend[i] and stores the type in a per-button slot, on the same edge as detection.
- Posting while pend[i] is already 1 and not granted that edge: the new type overwrites the slot, and ovf is set (sticky until rst).
- Arbiter:
  - When evt_valid=0, or on an ack edge, it searches pend starting at pointer, wrapping modulo NUM_BTN.
  - First hit j: load evt_id=j and evt_type=slot[j], set evt_valid=1, clear pend[j], set pointer to (j+1) mod NUM_BTN.
  - No hit: evt_valid goes 0 (on ack) or stays 0.
- Latency: a press sampled at edge k gives pend set after k and evt_valid=1 after edge k+1, provided the channel is free.
- Back-to-back: on an ack edge with another pend bit set, evt_valid stays 1 and the next event loads; there is no idle bubble.
- While evt_valid=1 and no ack, evt_id and evt_type are held stable.
- Same-edge grant of button j and a new post on button j: the grant takes the old slot value, pend[j] remains 1 with the new type, and ovf is not set.
- Counters saturate-free: they are always cleared before wrap because CNT_W is sized per the parameter rule.
- rst asserted mid-operation: immediate return to reset values, and any unacked event is discarded.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined: HELD/REPEAT generate REPEAT events as described.
- Undefined: HELD is terminal until release, no REPEAT is ever posted, and the REPEAT state and its counter compare are removed. LONG and RELEASE are unchanged.

Test Plan:
- rst pulse mid-event with evt_valid=1 -> all outputs 0 asynchronously, no event after release of rst until a new press.
- btn_deb[1] 0->1 at edge 10, evt_ack held 1 -> evt_valid=1 after edge 11 with id=1, type=00; held 50 cycles then released -> RELEASE (11) event, no LONG.
- btn_deb[0] held 300 cycles, ack always 1 -> PRESS, then LONG 200 cycles after press. With BTN_AUTOREPEAT_EN: REPEATs at +40 and +80 after LONG, then RELEASE. Without it: PRESS, LONG, RELEASE only.
- Buttons 0, 2, 3 pressed on same edge, ack held 1 -> three consecutive valid cycles with ids 0, 2, 3. Next simultaneous press of 0 and 3 -> order 0, 3 (pointer at 0 after wrap from 3).
- Button 2 pressed and released with evt_ack=0 -> PRESS granted and held stable. Pending RELEASE stays in slot; a second press/release overwrites it -> ovf=1 and remains 1 after draining.
- Ack edge coincides with a new post on the same button being granted -> evt_valid stays high, next cycle shows the new event, ovf stays 0.
